// File: rtl/vend_pkg.sv
// Shared coin codes, coin values and FSM state type for the change dispenser.
package vend_pkg;

    localparam int NUM_DENOM = 6;

    localparam logic [2:0] PS25    = 3'd0;
    localparam logic [2:0] PS50    = 3'd1;
    localparam logic [2:0] RS1     = 3'd2;
    localparam logic [2:0] RS2     = 3'd3;
    localparam logic [2:0] RS5     = 3'd4;
    localparam logic [2:0] RS10    = 3'd5;
    localparam logic [2:0] INVALID = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] code;
    } coin_sel_t;

    function automatic logic [15:0] coin_value(input logic [2:0] code);
        case (code)
            PS25:    return 16'd25;
            PS50:    return 16'd50;
            RS1:     return 16'd100;
            RS2:     return 16'd200;
            RS5:     return 16'd500;
            RS10:    return 16'd1000;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Request, coin-ejection, refill and status signals of the change dispenser.
interface vend_change_dispenser_if
    import vend_pkg::*;
#(
    parameter int STOCK_W = 8
);
    logic                 change_valid;
    logic [15:0]          change_amount;
    logic                 change_ready;
    logic [2:0]           coin_out;
    logic                 coin_out_valid;
    logic                 coin_out_ack;
    logic                 refill_valid;
    logic [2:0]           refill_denom;
    logic [STOCK_W-1:0]   refill_count;
    logic [NUM_DENOM-1:0] stock_empty;
    logic                 done;
    logic [15:0]          shortfall;
    logic [7:0]           coins_issued;

    modport master (
        output change_valid, change_amount, coin_out_ack,
               refill_valid, refill_denom, refill_count,
        input  change_ready, coin_out, coin_out_valid,
               stock_empty, done, shortfall, coins_issued
    );

    modport slave (
        input  change_valid, change_amount, coin_out_ack,
               refill_valid, refill_denom, refill_count,
        output change_ready, coin_out, coin_out_valid,
               stock_empty, done, shortfall, coins_issued
    );
endinterface

// File: rtl/vend_coin_stock.sv
// Per-denomination saturating coin stock counters with refill and single-coin decrement.
module vend_coin_stock
    import vend_pkg::*;
#(
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 8
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 refill_valid_i,
    input  logic [2:0]           refill_denom_i,
    input  logic [STOCK_W-1:0]   refill_count_i,
    input  logic                 dec_valid_i,
    input  logic [2:0]           dec_denom_i,
    output logic [NUM_DENOM-1:0] empty_o,
    output logic [NUM_DENOM-1:0] nonzero_o
);

    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_cnt
        logic [STOCK_W-1:0] cnt_q;
        logic [STOCK_W-1:0] cnt_d;
        logic [STOCK_W:0]   sum;

        // Add before subtracting: a decrement only happens on a nonzero count,
        // so the extra bit only ever carries overflow, never borrow.
        always_comb begin
            sum = {1'b0, cnt_q};
            if (refill_valid_i && refill_denom_i == 3'(g))
                sum = sum + {1'b0, refill_count_i};
            if (dec_valid_i && dec_denom_i == 3'(g))
                sum = sum - {{STOCK_W{1'b0}}, 1'b1};
            cnt_d = sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
        end

        always_ff @(posedge pclk) begin
            if (prst) cnt_q <= STOCK_W'(INIT_STOCK);
            else      cnt_q <= cnt_d;
        end

        assign empty_o[g]   = (cnt_q == '0);
        assign nonzero_o[g] = (cnt_q != '0);
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Greedy change payout: one coin per SELECT/ISSUE round, largest stocked coin that fits.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 8
) (
    input logic                     pclk,
    input logic                     prst,
    vend_change_dispenser_if.slave  bus
);

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] shortfall_q, shortfall_d;
    logic [7:0]  coins_q, coins_d;
    logic [2:0]  coin_q, coin_d;
    logic        dec_valid;
    coin_sel_t   sel;

    logic [NUM_DENOM-1:0] stock_empty;
    logic [NUM_DENOM-1:0] stock_nz;

    vend_coin_stock #(
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .pclk           (pclk),
        .prst           (prst),
        .refill_valid_i (bus.refill_valid),
        .refill_denom_i (bus.refill_denom),
        .refill_count_i (bus.refill_count),
        .dec_valid_i    (dec_valid),
        .dec_denom_i    (coin_q),
        .empty_o        (stock_empty),
        .nonzero_o      (stock_nz)
    );

    // Ascending scan, last hit wins: yields the largest coin that fits and is stocked.
    always_comb begin
        sel = '{vld: 1'b0, code: INVALID};
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (stock_nz[i] && coin_value(3'(i)) <= remaining_q) begin
                sel.vld  = 1'b1;
                sel.code = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        coins_d     = coins_q;
        coin_d      = coin_q;
        dec_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.change_valid) begin
                    remaining_d = bus.change_amount;
                    coins_d     = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel.vld) begin
                    coin_d  = sel.code;
                    state_d = S_ISSUE;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = S_DONE;
                end
            end
            S_ISSUE: begin
                if (bus.coin_out_ack) begin
                    dec_valid   = 1'b1;
                    remaining_d = remaining_q - coin_value(coin_q);
                    if (coins_q != 8'hFF) coins_d = coins_q + 8'd1;
                    state_d = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            coins_q     <= '0;
            coin_q      <= PS25;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            coins_q     <= coins_d;
            coin_q      <= coin_d;
        end
    end

    assign bus.change_ready   = (state_q == S_IDLE);
    assign bus.coin_out_valid = (state_q == S_ISSUE);
    assign bus.coin_out       = coin_q;
    assign bus.done           = (state_q == S_DONE);
    assign bus.shortfall      = shortfall_q;
    assign bus.coins_issued   = coins_q;
    assign bus.stock_empty    = stock_empty;

endmodule
